// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the fetch / load-store memory arbiter.
package arm_mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_XFER = 2'd1,
    LS_XFER = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/arm_mem_starve_ctr.sv
// Saturating count of load/store grants issued while a fetch is waiting;
// starve flags that the next idle arbitration must go to the fetch side.
module arm_mem_starve_ctr #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle,
  input  logic if_req,
  input  logic ls_grant,
  input  logic if_grant,
  output logic starve
);

  localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (if_grant || (idle && !if_req)) begin
      cnt_d = '0;
    end else if (ls_grant && if_req && (cnt_q != CNT_W'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign starve = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/arm_mem_arbiter.sv
// Arbitrates instruction fetch and load/store onto one single-outstanding memory port.
// Define ARM_MEM_ARB_STARVE_GUARD_EN to bound fetch starvation by load/store traffic.
module arm_mem_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_rvalid,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                ls_rvalid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned BE_W = DATA_W / 8;

  state_e            state_q, state_d;
  owner_e            pick_own;
  logic              idle, starve, pick, pick_if, pick_ls;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]   mem_be_q, mem_be_d;
  logic              if_gnt_q, if_gnt_d, ls_gnt_q, ls_gnt_d;
  logic              if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;

  assign idle = (state_q == IDLE);

`ifdef ARM_MEM_ARB_STARVE_GUARD_EN
  arm_mem_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .idle    (idle),
    .if_req  (if_req),
    .ls_grant(pick_ls),
    .if_grant(pick_if),
    .starve  (starve)
  );
`else
  // Strict load/store priority; the limit has no effect in this build.
  assign starve = (STARVE_LIMIT == 0) & 1'b0;
`endif

  // Load/store wins unless a waiting fetch has been passed over too often.
  assign pick_own = (ls_req && !(starve && if_req)) ? OWN_LS : OWN_IF;
  assign pick     = idle && (if_req || ls_req);
  assign pick_ls  = pick && (pick_own == OWN_LS);
  assign pick_if  = pick && (pick_own == OWN_IF);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_ls)      state_d = LS_XFER;
        else if (pick_if) state_d = IF_XFER;
      end
      IF_XFER, LS_XFER: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != IDLE);
    mem_req = busy;
  end

  // NOTE: every always_comb output gets a default first, otherwise a latch is inferred.
  always_comb begin
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if (pick_ls) begin
      mem_we_d    = ls_we;
      mem_addr_d  = ls_addr;
      mem_wdata_d = ls_wdata;
      mem_be_d    = ls_be;
    end else if (pick_if) begin
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr & ~ADDR_W'(3);
      mem_wdata_d = '0;
      mem_be_d    = '1;
    end
    if_gnt_d    = pick_if;
    ls_gnt_d    = pick_ls;
    if_rvalid_d = (state_q == IF_XFER) && mem_ready;
    ls_rvalid_d = (state_q == LS_XFER) && mem_ready;
    if_rdata_d  = if_rvalid_d ? mem_rdata : if_rdata_q;
    // Write completions pulse rvalid but leave the last read data visible.
    ls_rdata_d  = (ls_rvalid_d && !mem_we_q) ? mem_rdata : ls_rdata_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_gnt_q    <= 1'b0;
      ls_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_gnt_q    <= if_gnt_d;
      ls_gnt_q    <= ls_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_gnt    = if_gnt_q;
  assign ls_gnt    = ls_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_arm_mem_arbiter.sv
// Directed and randomized checks of arm_mem_arbiter against a transaction-level model.
module tb_arm_mem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;
  localparam int LIMIT  = 4;
`ifdef ARM_MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_gnt, if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ls_req = 1'b0;
  logic              ls_we = 1'b0;
  logic [ADDR_W-1:0] ls_addr = '0;
  logic [DATA_W-1:0] ls_wdata = '0;
  logic [BE_W-1:0]   ls_be = '0;
  logic              ls_gnt, ls_rvalid;
  logic [DATA_W-1:0] ls_rdata;
  logic              mem_req, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ready = 1'b0;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              busy;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_if_rdata = '0;
  logic [DATA_W-1:0] exp_ls_rdata = '0;

  always #5 clk = ~clk;

  arm_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rdata(if_rdata), .if_rvalid(if_rvalid),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
    .ls_gnt(ls_gnt), .ls_rdata(ls_rdata), .ls_rvalid(ls_rvalid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [255:0] obs;
    rst = 1'b0;
    repeat (3) step();
    obs = {if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy, mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, ls_rdata};
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
    // Release with a fetch already pending: the first live edge must arbitrate it.
    if_req = 1'b1; if_addr = 32'h0000_0040;
    rst = 1'b1;
    step();
    total++;
    if (if_gnt !== 1'b1) begin bad++; $display("FAIL first_arb if_gnt got=%b want=1", if_gnt); end
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    step();
    exp_if_rdata = 32'h1111_2222;
    total++;
    if ({if_rvalid, if_rdata} !== {1'b1, exp_if_rdata})
      begin bad++; $display("FAIL first_arb rvalid/rdata got=%b/%h want=1/%h", if_rvalid, if_rdata, exp_if_rdata); end
    mem_ready = 1'b0;
    step();
  endtask

  task automatic test_fetch();
    if_req = 1'b1; if_addr = 32'h0000_000E;
    step();
    total++;
    if ({if_gnt, ls_gnt, mem_req, busy, mem_we} !== 5'b10110)
      begin bad++; $display("FAIL fetch_gnt flags got=%b want=10110", {if_gnt, ls_gnt, mem_req, busy, mem_we}); end
    total++;
    if ({mem_addr, mem_be} !== {32'h0000_000C, 4'hF})
      begin bad++; $display("FAIL fetch_addr got=%h/%h want=0000000c/f", mem_addr, mem_be); end
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hE3A0_1005;
    step();
    exp_if_rdata = 32'hE3A0_1005;
    total++;
    if ({if_rvalid, if_gnt, mem_req, busy, if_rdata} !== {4'b1000, exp_if_rdata})
      begin bad++; $display("FAIL fetch_rvalid got=%b/%h want=1000/%h", {if_rvalid, if_gnt, mem_req, busy}, if_rdata, exp_if_rdata); end
    mem_ready = 1'b0;
    step();
    total++;
    if (if_rvalid !== 1'b0) begin bad++; $display("FAIL fetch_rvalid_pulse got=%b want=0", if_rvalid); end
  endtask

  task automatic test_priority();
    if_req = 1'b1; if_addr = 32'h0000_0104;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0; ls_wdata = 32'h0000_0005; ls_be = 4'hF;
    step();
    total++;
    if ({ls_gnt, if_gnt, mem_we, mem_addr, mem_wdata, mem_be} !== {3'b101, 32'h0, 32'h5, 4'hF})
      begin bad++; $display("FAIL prio_ls_first got=%b%b%b/%h/%h/%h want=101/0/5/f", ls_gnt, if_gnt, mem_we, mem_addr, mem_wdata, mem_be); end
    ls_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    step();
    total++;
    if ({ls_rvalid, if_rvalid, ls_rdata} !== {2'b10, exp_ls_rdata})
      begin bad++; $display("FAIL prio_write_done got=%b%b/%h want=10/%h", ls_rvalid, if_rvalid, ls_rdata, exp_ls_rdata); end
    mem_ready = 1'b0;
    step();
    total++;
    if ({if_gnt, ls_gnt, mem_we, mem_addr} !== {3'b100, 32'h0000_0104})
      begin bad++; $display("FAIL prio_if_second got=%b%b%b/%h want=100/00000104", if_gnt, ls_gnt, mem_we, mem_addr); end
    if_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h0A0B_0C0D;
    step();
    exp_if_rdata = 32'h0A0B_0C0D;
    total++;
    if ({if_rvalid, if_rdata} !== {1'b1, exp_if_rdata})
      begin bad++; $display("FAIL prio_if_data got=%b/%h want=1/%h", if_rvalid, if_rdata, exp_if_rdata); end
    mem_ready = 1'b0;
    step();
  endtask

  task automatic test_wait_states();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0100; ls_be = 4'h3; mem_ready = 1'b0;
    step();
    total++;
    if (ls_gnt !== 1'b1) begin bad++; $display("FAIL wait_gnt got=%b want=1", ls_gnt); end
    ls_req = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      total++;
      if ({mem_req, ls_rvalid, ls_gnt && (c > 0), mem_addr, mem_be} !== {3'b100, 32'h0000_0100, 4'h3})
        begin bad++; $display("FAIL wait_hold cyc=%0d got=%b%b/%h/%h want=10/00000100/3", c, mem_req, ls_rvalid, mem_addr, mem_be); end
      mem_ready = (c == 3); mem_rdata = 32'h5A5A_1234;
    end
    step();
    exp_ls_rdata = 32'h5A5A_1234;
    total++;
    if ({ls_rvalid, mem_req, ls_rdata} !== {2'b10, exp_ls_rdata})
      begin bad++; $display("FAIL wait_done got=%b%b/%h want=10/%h", ls_rvalid, mem_req, ls_rdata, exp_ls_rdata); end
    mem_ready = 1'b0;
    step();
    total++;
    if ({ls_rvalid, busy} !== 2'b00) begin bad++; $display("FAIL wait_single_rvalid got=%b want=00", {ls_rvalid, busy}); end
  endtask

  task automatic test_starve();
    int got[$];
    int want;
    int cnt = 0;
    if_req = 1'b1; if_addr = 32'h0000_1000;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_2000; ls_be = 4'hF;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0000;
    for (int c = 0; c < 60 && got.size() < 10; c++) begin
      step();
      total++;
      if ((if_gnt && ls_gnt) || (if_rvalid && ls_rvalid))
        begin bad++; $display("FAIL starve_exclusive cyc=%0d gnt=%b%b rvalid=%b%b", c, if_gnt, ls_gnt, if_rvalid, ls_rvalid); end
      if (if_gnt) got.push_back(1);
      if (ls_gnt) got.push_back(2);
    end
    if_req = 1'b0; ls_req = 1'b0;
    step();
    mem_ready = 1'b0;
    step();
    exp_ls_rdata = 32'hCAFE_0000;
    if (GUARD) exp_if_rdata = 32'hCAFE_0000;
    total++;
    if (got.size() != 10) begin bad++; $display("FAIL starve_timeout grants=%0d want=10", got.size()); end
    for (int i = 0; i < got.size(); i++) begin
      if (GUARD && cnt == LIMIT) begin want = 1; cnt = 0; end
      else begin want = 2; if (cnt < LIMIT) cnt++; end
      total++;
      if (got[i] !== want) begin bad++; $display("FAIL starve_seq idx=%0d got=%0d want=%0d (1=IF 2=LS)", i, got[i], want); end
    end
  endtask

  task automatic test_reset_mid();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_0200; ls_be = 4'hF; mem_ready = 1'b0;
    step();
    total++;
    if ({ls_gnt, mem_req} !== 2'b11) begin bad++; $display("FAIL rstmid_gnt got=%b want=11", {ls_gnt, mem_req}); end
    ls_req = 1'b0;
    #2 rst = 1'b0;
    #1;
    exp_if_rdata = '0;
    exp_ls_rdata = '0;
    total++;
    if ({mem_req, busy, ls_gnt, mem_addr, mem_be, ls_rdata, if_rdata} !== '0)
      begin bad++; $display("FAIL rstmid_immediate got=%b%b%b/%h/%h/%h/%h want=000/0/0/0/0", mem_req, busy, ls_gnt, mem_addr, mem_be, ls_rdata, if_rdata); end
    mem_ready = 1'b1;
    step();
    rst = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      total++;
      if ({ls_rvalid, if_rvalid, busy, mem_req} !== 4'b0000)
        begin bad++; $display("FAIL rstmid_dropped cyc=%0d got=%b want=0000", c, {ls_rvalid, if_rvalid, busy, mem_req}); end
    end
    mem_ready = 1'b0;
    step();
  endtask

  // Transaction-level model: pending requests, current owner, grant/rvalid predictions.
  task automatic test_random();
    logic              p_if = 1'b0, p_ls = 1'b0;
    logic [ADDR_W-1:0] a_if = '0, a_ls = '0, e_addr = '0;
    logic [DATA_W-1:0] wd_ls = '0, e_wd = '0;
    logic [BE_W-1:0]   be_ls = '0, e_be = '0;
    logic              we_ls = 1'b0, e_we = 1'b0;
    logic              e_ig = 1'b0, e_lg = 1'b0, e_ir = 1'b0, e_lr = 1'b0;
    int owner = 0;  // 0 free, 1 fetch, 2 load/store
    int cnt = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      step();
      total++;
      if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy, mem_req} !== {e_ig, e_lg, e_ir, e_lr, owner != 0, owner != 0})
        begin bad++; $display("FAIL rand_ctrl cyc=%0d got=%b want=%b", cyc, {if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy, mem_req}, {e_ig, e_lg, e_ir, e_lr, owner != 0, owner != 0}); end
      total++;
      if ({if_rdata, ls_rdata} !== {exp_if_rdata, exp_ls_rdata})
        begin bad++; $display("FAIL rand_rdata cyc=%0d got=%h/%h want=%h/%h", cyc, if_rdata, ls_rdata, exp_if_rdata, exp_ls_rdata); end
      if (owner != 0) begin
        total++;
        if ({mem_we, mem_addr, mem_wdata, mem_be} !== {e_we, e_addr, e_wd, e_be})
          begin bad++; $display("FAIL rand_mem cyc=%0d got=%b/%h/%h/%h want=%b/%h/%h/%h", cyc, mem_we, mem_addr, mem_wdata, mem_be, e_we, e_addr, e_wd, e_be); end
      end
      if (!p_if && $urandom_range(0, 99) < 40) begin p_if = 1'b1; a_if = $urandom; end
      if (!p_ls && $urandom_range(0, 99) < 50) begin
        p_ls = 1'b1; we_ls = 1'($urandom); a_ls = $urandom; wd_ls = $urandom; be_ls = BE_W'($urandom);
      end
      if_req = p_if; if_addr = a_if;
      ls_req = p_ls; ls_we = we_ls; ls_addr = a_ls; ls_wdata = wd_ls; ls_be = be_ls;
      mem_ready = ($urandom_range(0, 99) < 60); mem_rdata = $urandom;
      e_ig = 1'b0; e_lg = 1'b0; e_ir = 1'b0; e_lr = 1'b0;
      if (owner == 0) begin
        if (!p_if) cnt = 0;
        if (p_ls && !(GUARD && cnt == LIMIT && p_if)) begin
          owner = 2; e_lg = 1'b1;
          e_we = we_ls; e_addr = a_ls; e_wd = wd_ls; e_be = be_ls;
          if (GUARD && p_if && cnt < LIMIT) cnt++;
          p_ls = 1'b0;
        end else if (p_if) begin
          owner = 1; e_ig = 1'b1;
          e_we = 1'b0; e_addr = {a_if[ADDR_W-1:2], 2'b00}; e_wd = '0; e_be = '1;
          cnt = 0;
          p_if = 1'b0;
        end
      end else if (mem_ready) begin
        if (owner == 1) begin e_ir = 1'b1; exp_if_rdata = mem_rdata; end
        else begin e_lr = 1'b1; if (!e_we) exp_ls_rdata = mem_rdata; end
        owner = 0;
      end
    end
    if_req = 1'b0; ls_req = 1'b0; mem_ready = 1'b1;
    repeat (3) step();
    mem_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_wait_states();
    test_starve();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/arm_mem_arbiter.md
ARM_MEM_ARBITER -- requirements
Module: arm_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL have parameter DATA_W, default 32, memory data width; byte enables DATA_W/8 wide.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive load/store grants allowed while a fetch waits.
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have fetch ports: if_req in 1 fetch request; if_addr in ADDR_W fetch address; if_gnt out 1 grant pulse; if_rdata out DATA_W fetched word; if_rvalid out 1 fetch data valid pulse.
REQ-006 SHALL have load/store ports: ls_req in 1; ls_we in 1 write=1; ls_addr in ADDR_W; ls_wdata in DATA_W; ls_be in DATA_W/8; ls_gnt out 1; ls_rdata out DATA_W; ls_rvalid out 1 read data / write-done pulse.
REQ-007 SHALL have memory ports: mem_req out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_be out DATA_W/8; mem_ready in 1 transfer accepted/completed; mem_rdata in DATA_W valid when mem_ready=1.
REQ-008 SHALL have busy out 1, high whenever state is not IDLE.

Function
REQ-009 SHALL implement FSM states IDLE, IF_XFER, LS_XFER.
REQ-010 IDLE: ls_req=1 and no starve override -> LS_XFER; else if_req=1 -> IF_XFER; else stay IDLE.
REQ-011 Requesters hold req and address/data stable until the corresponding gnt; arbiter ignores de-asserted req.
REQ-012 if_gnt/ls_gnt SHALL be registered, high exactly one cycle: the first cycle of IF_XFER/LS_XFER.
REQ-013 On the IDLE->XFER edge, address, we, wdata, be SHALL be latched into mem_* registers; mem_req=1 from that cycle.
REQ-014 IF_XFER: mem_we=0, mem_be all ones, mem_addr[1:0]=2'b00 (word-aligned fetch).
REQ-015 XFER states: hold mem_req and mem_* stable until mem_ready=1 sampled; then next cycle mem_req=0, state IDLE, rvalid of owning side=1 for one cycle, rdata=registered mem_rdata (writes: ls_rdata unchanged, ls_rvalid still pulses).
REQ-016 Latency: req in IDLE cycle N, mem_ready=1 in N+1 -> rvalid in N+2; back-to-back grants every 2 cycles minimum.
REQ-017 Arbitration only in IDLE; requests during XFER wait, never preempt.
REQ-018 if_rvalid and ls_rvalid SHALL never be high in the same cycle; if_gnt and ls_gnt likewise.
REQ-019 mem_ready while IDLE SHALL be ignored.

Reset
REQ-020 rst=0 SHALL immediately force state IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, all gnt/rvalid=0, rdata=0, busy=0, starve counter=0.
REQ-021 Transfer in flight at reset SHALL be dropped; no rvalid after reset release for it.
REQ-022 First arbitration SHALL occur on the first rising edge with rst=1.

Configuration
REQ-023 Macro ARM_MEM_ARB_STARVE_GUARD_EN defined: saturating counter counts ls grants issued while if_req=1; when count=STARVE_LIMIT and if_req=1, IDLE grants fetch; counter clears on every fetch grant and when if_req=0 in IDLE.
REQ-024 Macro undefined: strict load/store priority, no counter logic present.

Structure
REQ-025 Shared package arm_mem_pkg SHALL hold the FSM state enum, ADDR_W/DATA_W defaults, and owner encoding (OWN_IF, OWN_LS).
REQ-026 Starvation counter SHALL be sub-module arm_mem_starve_ctr, instantiated only under ARM_MEM_ARB_STARVE_GUARD_EN.

Verification
REQ-027 Fetch only: if_req=1, if_addr=0x0000000E, mem_ready=1 next cycle, mem_rdata=0xE3A01005 -> if_gnt cycle 1, mem_addr=0x0000000C, if_rvalid cycle 2 with if_rdata=0xE3A01005.
REQ-028 Simultaneous if_req and ls_req (write 0x00000005 to 0x00000000, be=0xF) -> ls_gnt first, mem_we=1, ls_rvalid pulse, then if_gnt.
REQ-029 Wait states: mem_ready low 3 cycles -> mem_req and mem_addr stable 4 cycles, single rvalid after mem_ready.
REQ-030 Guard enabled, STARVE_LIMIT=4, ls_req and if_req held high -> grant sequence LS,LS,LS,LS,IF,LS...; guard disabled -> LS only.
REQ-031 rst=0 asserted mid LS_XFER -> mem_req=0 same cycle, no ls_rvalid after release, busy=0.
